// File: rtl/sb_credit_pkg.sv
// Shared types and constants for the sideband credit-loop controller.
//   ret_state_e       : encoding of the credit-return FSM
//   DefaultAdpSrcid   : srcid value that marks adapter-originated TX entries
package sb_credit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StPulse = 2'b01,
    StGap   = 2'b10
  } ret_state_e;

  localparam logic [1:0] DefaultAdpSrcid = 2'b01;

endpackage

// File: rtl/sb_sat_updown_cnt.sv
// Saturating up/down counter with a ceiling.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : force the count to 0 (highest priority)
//   load_i        : load the count with Ceiling
//   inc_i, dec_i  : +1 / -1 requests; both together leave the count unchanged
//   cnt_o         : current count
//   err_o         : combinational, high when an inc at Ceiling or a dec at 0 is dropped
module sb_sat_updown_cnt #(
  parameter int unsigned       Width   = 4,
  parameter logic [Width-1:0]  Ceiling = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [Width-1:0] cnt_o,
  output logic             err_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = Ceiling;
    end else if (inc_i && !dec_i) begin
      if (cnt_q >= Ceiling) begin
        err_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) begin
        err_o = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sb_credit_loop_ctrl_p.sv
// Sideband credit-loop controller for the RDI sideband path.
// Tracks the RX credits the PHY holds for pl_cfg delivery to the adapter and
// returns credits to the adapter as o_pl_cfg_crd pulses for each adapter-sourced
// TX FIFO pop, with optional idle spacing between pulses.
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_pl_inband_pres          : link present
//   i_lp_cfg_crd              : adapter returns one RX credit
//   i_rising_edge_pl_cfg_vld  : one message delivered to the adapter
//   i_tx_fifo_read_en         : TX FIFO pop
//   i_srcid                   : srcid of the popped entry
//   i_fifo_data_is_zeros      : popped entry is filler
//   i_crd_err_clr             : clears o_crd_err
//   o_pl_cfg_crd              : credit-return pulse
//   o_adapter_is_full         : RX credit count is zero
//   o_rx_crd, o_pend_crd      : RX credits, credits awaiting return
//   o_crd_err                 : sticky overflow/underflow flag
module sb_credit_loop_ctrl_p
  import sb_credit_pkg::*;
#(
  parameter int unsigned        CRD_W       = 6,
  parameter int unsigned        INIT_RX_CRD = 32,
  parameter int unsigned        PEND_W      = 4,
  parameter int unsigned        SRCID_W     = 2,
  parameter logic [SRCID_W-1:0] ADP_SRCID   = SRCID_W'(DefaultAdpSrcid),
  parameter int unsigned        RET_GAP     = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pl_inband_pres,
  input  logic               i_lp_cfg_crd,
  input  logic               i_rising_edge_pl_cfg_vld,
  input  logic               i_tx_fifo_read_en,
  input  logic [SRCID_W-1:0] i_srcid,
  input  logic               i_fifo_data_is_zeros,
  input  logic               i_crd_err_clr,
  output logic               o_pl_cfg_crd,
  output logic               o_adapter_is_full,
  output logic [CRD_W-1:0]   o_rx_crd,
  output logic [PEND_W-1:0]  o_pend_crd,
  output logic               o_crd_err
);

  localparam bit                  HasGap  = (RET_GAP > 0);
  localparam int unsigned         GapW    = (RET_GAP > 1) ? $clog2(RET_GAP) : 1;
  localparam logic [GapW-1:0]     GapLoad = GapW'((RET_GAP > 0) ? RET_GAP - 1 : 0);
  localparam logic [CRD_W-1:0]    RxCeil  = CRD_W'(INIT_RX_CRD);
  localparam logic [PEND_W-1:0]   PendOne = PEND_W'(1);

  // Link state: pres_q is the registered input, pres_d1_q its previous value.
  logic pres_q, pres_d1_q;
  logic link_rise;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pres_q    <= 1'b0;
      pres_d1_q <= 1'b0;
    end else begin
      pres_q    <= i_pl_inband_pres;
      pres_d1_q <= pres_q;
    end
  end

  assign link_rise = pres_q & ~pres_d1_q;

  // Events only count while the link is up.
  logic ret_event, rx_inc, rx_dec, err_clr;

  assign ret_event = pres_q & i_tx_fifo_read_en & (i_srcid == ADP_SRCID) & ~i_fifo_data_is_zeros;
  assign rx_inc    = pres_q & i_lp_cfg_crd;
  assign rx_dec    = pres_q & i_rising_edge_pl_cfg_vld;
  assign err_clr   = pres_q & i_crd_err_clr;

  ret_state_e state_q, state_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            issue;

  assign issue = (state_q == StPulse);

  logic [CRD_W-1:0]  rx_crd;
  logic [PEND_W-1:0] pend;
  logic              rx_err, pend_err;

  sb_sat_updown_cnt #(
    .Width   (CRD_W),
    .Ceiling (RxCeil)
  ) u_rx_cnt (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clear_i (~pres_q),
    .load_i  (link_rise),
    .inc_i   (rx_inc),
    .dec_i   (rx_dec),
    .cnt_o   (rx_crd),
    .err_o   (rx_err)
  );

  sb_sat_updown_cnt #(
    .Width   (PEND_W),
    .Ceiling ({PEND_W{1'b1}})
  ) u_pend_cnt (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .clear_i (~pres_q | link_rise),
    .load_i  (1'b0),
    .inc_i   (ret_event),
    .dec_i   (issue),
    .cnt_o   (pend),
    .err_o   (pend_err)
  );

  // Return FSM.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    if (!pres_q) begin
      state_d = StIdle;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pend != '0) state_d = StPulse;
        end
        StPulse: begin
          if (HasGap) begin
            state_d = StGap;
            gap_d   = GapLoad;
          end else if ((pend > PendOne) || ret_event) begin
            // pend is at least 1 here; something remains after this decrement
            state_d = StPulse;
          end else begin
            state_d = StIdle;
          end
        end
        StGap: begin
          if (gap_q == '0) begin
            state_d = (pend != '0) ? StPulse : StIdle;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  // Sticky error; a new error wins over a simultaneous clear.
  logic crd_err_q, crd_err_d;

  always_comb begin
    crd_err_d = crd_err_q;
    if (rx_err || pend_err) begin
      crd_err_d = 1'b1;
    end else if (err_clr) begin
      crd_err_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crd_err_q <= 1'b0;
    end else begin
      crd_err_q <= crd_err_d;
    end
  end

  assign o_pl_cfg_crd      = issue;
  assign o_adapter_is_full = (rx_crd == '0);
  assign o_rx_crd          = rx_crd;
  assign o_pend_crd        = pend;
  assign o_crd_err         = crd_err_q;

endmodule

// File: tb/tb_sb_credit_loop_ctrl_p.sv
// Bench for sb_credit_loop_ctrl_p. Three instances differ only in RET_GAP
// (0, 2, 40); each has its own TX read enable, all other inputs are shared.
// Expected pulse cycles are queued when reads are driven and popped as pulses appear.
module tb_sb_credit_loop_ctrl_p;

  localparam logic [1:0] Adp = 2'b01;

  logic clk = 1'b0;
  logic rst_n;
  logic pres, lp_crd, vld, zeros, clr;
  logic [1:0] srcid;
  logic [2:0] rd_en;

  logic [2:0]      pulse, full, err;
  logic [2:0][5:0] rx;
  logic [2:0][3:0] pend;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sb_credit_loop_ctrl_p #(.RET_GAP(0)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pl_inband_pres(pres), .i_lp_cfg_crd(lp_crd),
    .i_rising_edge_pl_cfg_vld(vld), .i_tx_fifo_read_en(rd_en[0]), .i_srcid(srcid),
    .i_fifo_data_is_zeros(zeros), .i_crd_err_clr(clr), .o_pl_cfg_crd(pulse[0]),
    .o_adapter_is_full(full[0]), .o_rx_crd(rx[0]), .o_pend_crd(pend[0]), .o_crd_err(err[0])
  );

  sb_credit_loop_ctrl_p #(.RET_GAP(2)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pl_inband_pres(pres), .i_lp_cfg_crd(lp_crd),
    .i_rising_edge_pl_cfg_vld(vld), .i_tx_fifo_read_en(rd_en[1]), .i_srcid(srcid),
    .i_fifo_data_is_zeros(zeros), .i_crd_err_clr(clr), .o_pl_cfg_crd(pulse[1]),
    .o_adapter_is_full(full[1]), .o_rx_crd(rx[1]), .o_pend_crd(pend[1]), .o_crd_err(err[1])
  );

  sb_credit_loop_ctrl_p #(.RET_GAP(40)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pl_inband_pres(pres), .i_lp_cfg_crd(lp_crd),
    .i_rising_edge_pl_cfg_vld(vld), .i_tx_fifo_read_en(rd_en[2]), .i_srcid(srcid),
    .i_fifo_data_is_zeros(zeros), .i_crd_err_clr(clr), .o_pl_cfg_crd(pulse[2]),
    .o_adapter_is_full(full[2]), .o_rx_crd(rx[2]), .o_pend_crd(pend[2]), .o_crd_err(err[2])
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int gap_of(input int d);
    case (d)
      0:       return 0;
      1:       return 2;
      default: return 40;
    endcase
  endfunction

  task automatic push_exp(input int d, input int c);
    case (d)
      0:       q0.push_back(c);
      1:       q1.push_back(c);
      default: q2.push_back(c);
    endcase
  endtask

  // Pulse monitor: every pulse must match the oldest expected cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (pulse[d]) begin
          int e;
          e = -1;
          case (d)
            0:       if (q0.size() > 0) e = q0.pop_front();
            1:       if (q1.size() > 0) e = q1.pop_front();
            default: if (q2.size() > 0) e = q2.pop_front();
          endcase
          check_eq($sformatf("pulse_cycle[%0d]", d), cyc, e);
        end
      end
    end
  end

  // n consecutive reads into instance d; the first n_push are expected to return
  // a pulse at start + 2 + i*(gap+1).
  task automatic send_reads(input int d, input int n, input logic [1:0] sid,
                            input logic zrs, input int n_push);
    int start;
    start = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (i == 0) start = cyc;
      rd_en    = '0;
      rd_en[d] = 1'b1;
      srcid    = sid;
      zeros    = zrs;
      if (i < n_push) push_exp(d, start + 2 + i * (gap_of(d) + 1));
    end
    @(posedge clk); #1;
    rd_en = '0;
    srcid = Adp;
    zeros = 1'b0;
  endtask

  task automatic pulse_in(input int which);
    @(posedge clk); #1;
    case (which)
      0:       lp_crd = 1'b1;
      1:       vld = 1'b1;
      2:       begin lp_crd = 1'b1; vld = 1'b1; end
      default: clr = 1'b1;
    endcase
    @(posedge clk); #1;
    lp_crd = 1'b0;
    vld    = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pulse"}, pulse[0], 0);
    check_eq({tag, "_full"}, full[0], 1);
    check_eq({tag, "_rx"}, rx[0], 0);
    check_eq({tag, "_pend"}, pend[0], 0);
    check_eq({tag, "_err"}, err[0], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pres = 1'b0; lp_crd = 1'b0; vld = 1'b0; zeros = 1'b0; clr = 1'b0;
    srcid = Adp; rd_en = '0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;

    // Link down: credit return pulses are ignored
    pulse_in(0);
    @(negedge clk);
    check_eq("linkdown_rx", rx[0], 0);

    // Link-up: count appears two cycles after the input rises
    @(posedge clk); #1; pres = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("linkup_n1_rx", rx[0], 0);
    check_eq("linkup_n1_full", full[0], 1);
    @(negedge clk);
    check_eq("linkup_rx", rx[0], 32);
    check_eq("linkup_full", full[0], 0);
    check_eq("linkup_rx_g40", rx[2], 32);

    // Drain all 32 credits
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1; vld = 1'b1;
    end
    @(posedge clk); #1; vld = 1'b0;
    @(negedge clk);
    check_eq("drain_rx", rx[0], 0);
    check_eq("drain_full", full[0], 1);
    check_eq("drain_err", err[0], 0);

    // Underflow
    pulse_in(1);
    @(negedge clk);
    check_eq("underflow_rx", rx[0], 0);
    check_eq("underflow_err", err[0], 1);
    pulse_in(3);
    @(negedge clk);
    check_eq("err_clr", err[0], 0);

    pulse_in(0);
    @(negedge clk);
    check_eq("return_rx", rx[0], 1);
    check_eq("return_full", full[0], 0);
    pulse_in(2);
    @(negedge clk);
    check_eq("both_rx", rx[0], 1);
    check_eq("both_err", err[0], 0);

    // Back-to-back returns (gap 0), then gap 2
    send_reads(0, 3, Adp, 1'b0, 3);
    repeat (10) @(negedge clk);
    check_eq("gap0_drained", q0.size(), 0);
    check_eq("gap0_pend", pend[0], 0);
    send_reads(1, 3, Adp, 1'b0, 3);
    repeat (14) @(negedge clk);
    check_eq("gap2_drained", q1.size(), 0);
    check_eq("gap2_pend", pend[1], 0);

    // Non-adapter srcid and filler entries return nothing
    send_reads(0, 3, 2'b10, 1'b0, 0);
    @(negedge clk);
    check_eq("foreign_pend", pend[0], 0);
    send_reads(0, 3, Adp, 1'b1, 0);
    @(negedge clk);
    check_eq("filler_pend", pend[0], 0);
    repeat (5) @(negedge clk);

    // Saturation with gap 40: 17 reads starting at N; one pulse at N+2, pend
    // reaches 15 at N+16 and the 17th read overflows.
    send_reads(2, 17, Adp, 1'b0, 1);
    @(negedge clk);
    check_eq("sat_pend", pend[2], 15);
    check_eq("sat_err", err[2], 1);
    check_eq("sat_err_other", err[0], 0);

    // Link drop mid-burst: pending credits vanish, no further pulses
    @(posedge clk); #1; pres = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("drop_pend", pend[2], 0);
    check_eq("drop_rx", rx[2], 0);
    check_eq("drop_full", full[2], 1);
    repeat (40) @(negedge clk);
    check_eq("drop_drained", q2.size(), 0);

    // Relink, clear the error, then overflow at the ceiling
    @(posedge clk); #1; pres = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("relink_rx", rx[0], 32);
    pulse_in(3);
    @(negedge clk);
    check_eq("relink_err_clr", err[2], 0);
    pulse_in(0);
    @(negedge clk);
    check_eq("overflow_rx", rx[0], 32);
    check_eq("overflow_err", err[0], 1);

    // Asynchronous reset mid-burst (pulses due at N+2..N+4, reset during N+3)
    send_reads(0, 3, Adp, 1'b0, 3);
    @(negedge clk);
    check_eq("midburst_pend", pend[0], 2);
    check_eq("midburst_pulse", pulse[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    q0.delete();
    repeat (3) @(negedge clk);
    check_reset_vals("held_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_credit_loop_ctrl_p.md
# sb_credit_loop_ctrl_p

Parametrised sideband credit-loop controller for the RDI sideband path. It tracks the credits the PHY holds for delivering `pl_cfg` messages to the adapter, and drives `o_adapter_is_full` into the RDI decoder. It also returns credits to the adapter as `o_pl_cfg_crd` pulses once adapter-sourced entries leave the TX FIFO. Compared with the fixed controller, it adds configurable widths and initial credit, configurable return-pulse spacing, saturation with a sticky error flag, and link-down flushing.

## Interface
Parameters:
- `CRD_W`, 6: width of the RX credit counter.
- `INIT_RX_CRD`, 32: credits loaded on link-up; also the counter ceiling. Must be ≤ 2^CRD_W−1.
- `PEND_W`, 4: width of the pending-return counter.
- `SRCID_W`, 2: width of `i_srcid`.
- `ADP_SRCID`, 2'b01: srcid value identifying adapter-originated TX entries.
- `RET_GAP`, 0: idle cycles forced between consecutive `o_pl_cfg_crd` pulses. 0 means back-to-back pulses.

Ports:
- `i_clk` in 1: sideband clock. This is the only clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_pl_inband_pres` in 1: link present. The link is up while this is high.
- `i_lp_cfg_crd` in 1: one-cycle pulse; the adapter returns one RX credit.
- `i_rising_edge_pl_cfg_vld` in 1: one-cycle pulse from the decoder; one message was delivered to the adapter.
- `i_tx_fifo_read_en` in 1: the TX FIFO popped an entry.
- `i_srcid` in SRCID_W: srcid of the popped entry.
- `i_fifo_data_is_zeros` in 1: the popped entry is filler and is not a message.
- `i_crd_err_clr` in 1: clears `o_crd_err`.
- `o_pl_cfg_crd` out 1: credit-return pulse to the adapter.
- `o_adapter_is_full` out 1: high when the RX credit count is 0.
- `o_rx_crd` out CRD_W: current RX credit count.
- `o_pend_crd` out PEND_W: credits waiting to be returned.
- `o_crd_err` out 1: sticky error; set on any overflow or underflow.

## Operation
- **Link state.** `i_pl_inband_pres` is registered. A sampled 0→1 transition loads `rx_crd = INIT_RX_CRD` and clears `pend`.
- **Link down.** While the registered `i_pl_inband_pres` is 0:
  - `rx_crd` and `pend` are forced to 0.
  - The FSM is forced to IDLE.
  - All input events are ignored.
- **RX credit counter.** Each cycle, `rx_crd` changes by `+i_lp_cfg_crd − i_rising_edge_pl_cfg_vld`.
  - Both pulses in the same cycle: count unchanged.
  - Increment at `INIT_RX_CRD`: count holds and `o_crd_err` is set.
  - Decrement at 0: count holds at 0 and `o_crd_err` is set.
- **`o_adapter_is_full`** is decoded from the registered `rx_crd` (`rx_crd == 0`).
- **Return event.** A return event is `i_tx_fifo_read_en & (i_srcid == ADP_SRCID) & ~i_fifo_data_is_zeros`.
- **Pending counter.** Each cycle, `pend` changes by `+event − issue`, where `issue = (state == PULSE)`.
  - Event and issue in the same cycle: `pend` unchanged.
  - Increment at 2^PEND_W−1: `pend` saturates and `o_crd_err` is set.
- **Return FSM, states IDLE / PULSE / GAP:**
  - IDLE → PULSE when `pend > 0`.
  - PULSE lasts exactly one cycle. Its exit depends on `RET_GAP` and the remaining `pend` (after this cycle's decrement):
    - `RET_GAP > 0`: go to GAP and load the gap counter with `RET_GAP − 1`.
    - `RET_GAP == 0` and `pend` still > 0: stay in PULSE.
    - `RET_GAP == 0` and `pend` now 0: go to IDLE.
  - GAP counts down to 0, then goes to PULSE if `pend > 0`, otherwise to IDLE.
- **`o_crd_err`** clears on `i_crd_err_clr`. If a clear and a new error occur in the same cycle, the set wins.

## Timing
- **Reset values:** `rx_crd = 0`, `pend = 0`, state IDLE, `o_pl_cfg_crd = 0`, `o_adapter_is_full = 1`, `o_rx_crd = 0`, `o_pend_crd = 0`, `o_crd_err = 0`.
- **Link-up:** if `i_pl_inband_pres` rises at cycle N, then `o_rx_crd = INIT_RX_CRD` and `o_adapter_is_full = 0` from cycle N+2. One cycle comes from the input register and one from the load.
- **Credit update:** a credit pulse at cycle N is reflected in `o_rx_crd` and `o_adapter_is_full` at N+1.
- **Return latency:** a return event at N gives `pend = 1` at N+1 and `o_pl_cfg_crd` high for exactly cycle N+2.
- **Burst spacing:** with `RET_GAP = g`, consecutive pulses are separated by exactly g low cycles.
- **Link drop mid-operation:** if the drop is sampled at N, pending credits are discarded and there are no pulses from N+1. A pulse already high at cycle N completes normally.
- **Asynchronous reset:** takes effect immediately, in any state.

## Structure
- **Package `sb_credit_pkg`:** return-FSM state encoding (IDLE = 2'b00, PULSE = 2'b01, GAP = 2'b10) and the default `ADP_SRCID` constant.
- **Sub-module `sb_sat_updown_cnt`:** parameterised width and ceiling, with inc/dec/load/clear inputs and an error output. It is instantiated twice, once for `rx_crd` and once for `pend`.
- The FSM and gap counter live in the top module.

## Test plan
- Reset, then raise `i_pl_inband_pres` → `o_rx_crd = 32` and `o_adapter_is_full = 0` two cycles later.
- 32 `i_rising_edge_pl_cfg_vld` pulses → `o_adapter_is_full = 1`. A 33rd pulse → `o_crd_err = 1` and the count stays 0. A simultaneous `i_lp_cfg_crd` and `i_rising_edge_pl_cfg_vld` → count unchanged.
- Three adapter-srcid reads on consecutive cycles with `RET_GAP = 0` → three back-to-back `o_pl_cfg_crd` pulses starting 2 cycles after the first read. Repeat with `RET_GAP = 2` → each pulse is followed by exactly 2 low cycles.
- Reads with `i_srcid ≠ ADP_SRCID`, or with `i_fifo_data_is_zeros = 1` → no pulses and `o_pend_crd` stays 0.
- 16 return events while pulses are held off by a large `RET_GAP` → `o_pend_crd` saturates at 15 and `o_crd_err` sets. Drop `i_pl_inband_pres` mid-burst → `o_pend_crd = 0` and no further pulses. Assert `i_rst_n` mid-burst → all outputs return to their reset values immediately.
